// File: rtl/spireg_pkg.sv
// Shared constants for the SPI register receiver: frame geometry and register map.
// Latency: n/a (constants only).
// Backpressure: n/a.
package spireg_pkg;

  localparam int ADDR_W     = 4;
  localparam int DATA_W_DEF = 24;
  localparam int FRAME_BITS = ADDR_W + DATA_W_DEF;

  // Register map of the raycaster core
  localparam logic [ADDR_W-1:0] REG_SKY    = 4'd0;
  localparam logic [ADDR_W-1:0] REG_FLOOR  = 4'd1;
  localparam logic [ADDR_W-1:0] REG_LEAK   = 4'd2;
  localparam logic [ADDR_W-1:0] REG_OTHER  = 4'd3;
  localparam logic [ADDR_W-1:0] REG_VSHIFT = 4'd4;
  localparam logic [ADDR_W-1:0] REG_VINF   = 4'd5;
  localparam logic [ADDR_W-1:0] REG_MAPD   = 4'd6;
  localparam logic [ADDR_W-1:0] REG_TEXADD = 4'd7;

  // Frame length for a given payload width
  function automatic int frame_bits(input int data_w);
    return ADDR_W + data_w;
  endfunction

endpackage

// File: rtl/spi_reg_rx_if.sv
// Pin and register-bank bundle of the SPI register receiver.
// Latency: n/a (wires only).
// Backpressure: none; the bank is always valid.
interface spi_reg_rx_if
  import spireg_pkg::*;
#(
  parameter int NREGS  = 8,
  parameter int DATA_W = 24
);
  logic                    i_sclk;
  logic                    i_mosi;
  logic                    i_ss_n;
  logic                    i_vsync_n;
  logic [NREGS*DATA_W-1:0] o_regs;
  logic                    o_wr_pulse;
  logic [ADDR_W-1:0]       o_wr_addr;
  logic                    o_frame_err;

  modport slave (
    input  i_sclk, i_mosi, i_ss_n, i_vsync_n,
    output o_regs, o_wr_pulse, o_wr_addr, o_frame_err
  );

  modport master (
    output i_sclk, i_mosi, i_ss_n, i_vsync_n,
    input  o_regs, o_wr_pulse, o_wr_addr, o_frame_err
  );
endinterface

// File: rtl/spireg_sync.sv
// 2-FF synchronizer for an async pin plus a third FF for edge detection.
// Latency: level/edges valid 2 clk after the pin change.
// Backpressure: none.
module spireg_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic [2:0] ff_q;

  // Shift the pin through the synchronizer and history stage; reset to the idle level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff_q <= {3{RST_VAL}};
    else        ff_q <= {ff_q[1:0], d_i};
  end

  assign level_o = ff_q[1];
  assign rise_o  = ff_q[1] & ~ff_q[2];
  assign fall_o  = ~ff_q[1] & ff_q[2];
endmodule

// File: rtl/spi_reg_rx.sv
// SPI mode-0 register-write receiver presenting a flat always-valid register bank.
// Latency: 4 clk from ss_n pin rise to o_regs/o_wr_pulse/o_frame_err (needs f_sclk <= f_clk/4).
// Backpressure: none; optional SPIREG_VSYNC_COMMIT_EN defers bank updates to the vsync_n fall.
module spi_reg_rx
  import spireg_pkg::*;
#(
  parameter int NREGS  = 8,
  parameter int DATA_W = DATA_W_DEF,
  parameter logic [NREGS*DATA_W-1:0] RESET_VAL = '0
) (
  input logic         clk,
  input logic         rst_n,
  spi_reg_rx_if.slave bus
);
  localparam int FRM_BITS = frame_bits(DATA_W);
  localparam int CNT_W    = $clog2(FRM_BITS + 2);
  localparam int BANK_W   = NREGS * DATA_W;
  localparam int AW1      = ADDR_W + 1;

  logic sclk_rise, mosi_lvl, ss_lvl, ss_rise, ss_fall;
  logic sclk_lvl_unused, sclk_fall_unused, mosi_rise_unused, mosi_fall_unused;

  spireg_sync #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d_i(bus.i_sclk),
    .level_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall_unused));
  spireg_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d_i(bus.i_mosi),
    .level_o(mosi_lvl), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused));
  spireg_sync #(.RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst_n(rst_n), .d_i(bus.i_ss_n),
    .level_o(ss_lvl), .rise_o(ss_rise), .fall_o(ss_fall));

  logic [FRM_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                end_q, end_d;
  logic                ok_q, ok_d;

  // Frame shifter: select edges take priority over a coincident sclk edge
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    end_d   = 1'b0;
    ok_d    = 1'b0;
    if (ss_fall) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (ss_rise) begin
      end_d = 1'b1;
      ok_d  = (cnt_q == CNT_W'(FRM_BITS));
    end else if (sclk_rise && !ss_lvl) begin
      shift_d = {shift_q[FRM_BITS-2:0], mosi_lvl};
      // Saturate one past a full frame so overruns stay detectable
      if (cnt_q != CNT_W'(FRM_BITS + 1)) cnt_d = cnt_q + 1'b1;
    end
  end

  // Frame shifter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
      end_q   <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      end_q   <= end_d;
      ok_q    <= ok_d;
    end
  end

  logic [ADDR_W-1:0] frm_addr;
  logic [DATA_W-1:0] frm_data;
  logic              wr_en;

  // Shift register is stable for the cycle after the frame end, so decode it directly
  assign frm_addr = shift_q[FRM_BITS-1 -: ADDR_W];
  assign frm_data = shift_q[DATA_W-1:0];
  assign wr_en    = end_q && ok_q && ({1'b0, frm_addr} < AW1'(NREGS));

  logic [BANK_W-1:0] regs_q, regs_d;
  logic              pulse_q, pulse_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;

  assign err_d = end_q & ~ok_q;

`ifdef SPIREG_VSYNC_COMMIT_EN
  logic [BANK_W-1:0] shadow_q, shadow_d;
  logic [NREGS-1:0]  pend_q, pend_d;
  logic              vsync_q;
  logic              commit;
  logic [ADDR_W-1:0] low_addr;

  assign commit = vsync_q & ~bus.i_vsync_n;

  // Lowest pending address, reported with the commit pulse
  always_comb begin
    low_addr = '0;
    for (int k = NREGS - 1; k >= 0; k--) begin
      if (pend_q[k]) low_addr = ADDR_W'(k);
    end
  end

  // Commit uses the old pending set; a frame landing on the commit cycle waits for the next one
  always_comb begin
    regs_d   = regs_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    pulse_d  = 1'b0;
    addr_d   = addr_q;
    if (commit) begin
      for (int k = 0; k < NREGS; k++) begin
        if (pend_q[k]) regs_d[k*DATA_W +: DATA_W] = shadow_q[k*DATA_W +: DATA_W];
      end
      pend_d  = '0;
      pulse_d = |pend_q;
      if (|pend_q) addr_d = low_addr;
    end
    if (wr_en) begin
      for (int k = 0; k < NREGS; k++) begin
        if (frm_addr == ADDR_W'(k)) begin
          shadow_d[k*DATA_W +: DATA_W] = frm_data;
          pend_d[k] = 1'b1;
        end
      end
    end
  end

  // Shadow bank, pending flags and vsync history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      pend_q   <= '0;
      vsync_q  <= 1'b1;
    end else begin
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      vsync_q  <= bus.i_vsync_n;
    end
  end
`else
  logic unused_vsync;
  assign unused_vsync = bus.i_vsync_n;

  // Immediate write of a valid in-range frame
  always_comb begin
    regs_d  = regs_q;
    pulse_d = wr_en;
    addr_d  = addr_q;
    if (wr_en) begin
      addr_d = frm_addr;
      for (int k = 0; k < NREGS; k++) begin
        if (frm_addr == ADDR_W'(k)) regs_d[k*DATA_W +: DATA_W] = frm_data;
      end
    end
  end
`endif

  // Output register bank and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q  <= RESET_VAL;
      pulse_q <= 1'b0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      pulse_q <= pulse_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_regs      = regs_q;
  assign bus.o_wr_pulse  = pulse_q;
  assign bus.o_wr_addr   = addr_q;
  assign bus.o_frame_err = err_q;
endmodule
